adc_spi_sampler: RTL and testbench
==================================

Name: adc_spi_sampler

Overview:
- Upstream stage of the ADC low-pass filter: drives a 10-bit SPI ADC at a fixed sample rate and presents each conversion as a signed 10-bit sample with a one-cycle valid strobe.
- Converts the ADC's offset-binary code to two's complement (code 512 -> 0) so the filter averages around zero.
- Default rate is 200 samples/s, so the filter's 200-sample window spans 1 s.

Parameters:
- CLK_DIV, 25, system clocks per SCLK half-period; SCLK period = 2*CLK_DIV clocks; minimum 2.
- SAMPLE_PERIOD, 250000, system clocks between conversion starts (200 Hz at 50 MHz).
- CHANNEL, 0, ADC input channel (0 or 1), placed in the command word.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- Enable  input  1  high allows new conversions to start; an in-flight conversion always completes.
- AdcMiso  input  1  ADC serial data out.
- AdcSclk  output  1  SPI clock; idles low.
- AdcCsN  output  1  ADC chip select, active low.
- AdcMosi  output  1  ADC serial data in.
- DataOut  output  10 (signed)  latest sample, held between updates.
- DataValid  output  1  one-cycle pulse when DataOut updates.
- RangeError  output  1  one-cycle pulse on a malformed frame (see Optional Feature).

Behaviour:
- Reset values (asynchronous, immediate): AdcCsN=1, AdcSclk=0, AdcMosi=0, DataOut=0, DataValid=0, RangeError=0, state=IDLE, sample timer=0, divider=0, bit counter=0, pending=0.
- Sample timer:
  - Free-running, counts 0..SAMPLE_PERIOD-1 and wraps.
  - Wrap sets pending only when Enable=1.
  - A pending tick is consumed when IDLE starts a conversion.
  - Ticks arriving while busy do not queue beyond one pending.
- State machine:
  - IDLE: pending=1 -> CS_SETUP, AdcCsN falls, pending cleared.
  - CS_SETUP: hold CLK_DIV clocks with SCLK low -> SHIFT.
  - SHIFT: exactly 16 SCLK periods.
    - SCLK rises after CLK_DIV clocks low and falls after CLK_DIV clocks high.
    - AdcMisoBehaviour: AdcMiso is sampled into a 16-bit shift register (MSB first) on the system clock at which SCLK rises.
    - AdcMosi updates on SCLK falling edges and during CS_SETUP.
    - After the 16th falling edge -> CS_HOLD.
  - CS_HOLD: SCLK low, CS still low for CLK_DIV clocks, then AdcCsN=1 -> DONE.
  - DONE: one clock. DataOut <= {~rx[9], rx[8:0]}, DataValid=1 -> IDLE.
- Command word, MSB first: bit15=1 (start), bit14=1 (single-ended), bit13=CHANNEL[0], bit12=1 (MSB-first), bits 11..0=0.
  - Bit 15 is on AdcMosi from the CS falling edge.
- Frame format: rx[15:10] are don't-care/null bits; rx[9:0] is the unsigned conversion result.
- Conversion length: 2*CLK_DIV + 32*CLK_DIV + 1 clocks, from leaving IDLE to the DataValid pulse.
  - If SAMPLE_PERIOD is shorter than this, conversions run back to back via pending.
- Latency: DataValid asserts exactly one clock after AdcCsN returns high.
- Enable low mid-conversion: the frame completes and publishes, and pending is cleared.
- Reset mid-conversion: CS releases immediately, the partial frame is discarded, and no DataValid is produced.

Optional Feature:
- Macro: ADC_RANGE_CHECK_EN.
- With the macro: rx[15:11] must be 0 and rx[10] (null bit) must be 0.
  - Otherwise DONE pulses RangeError, holds DataOut unchanged and suppresses DataValid.
  - This guards the filter against a floating MISO line (all ones).
- Without the macro: RangeError is tied 0 and every frame publishes.

Test Plan (CLK_DIV=2, SAMPLE_PERIOD=100, CHANNEL=1):
- Reset then Enable=1; ADC model returns code 0x200 -> DataValid pulse 69 clocks after conversion start, DataOut=0. AdcMosi shows bits 1,1,1,1 then 0s; 16 SCLK rising edges per frame.
- Model returns 0x3FF, then 0x000, then 0x1FF -> DataOut = +511, -512, -1 on successive pulses 100 clocks apart.
- Enable dropped 10 clocks into SHIFT -> that frame still publishes; no further CS falls while Enable=0; next conversion starts at the first timer wrap after Enable returns high.
- Reset asserted during SHIFT -> AdcCsN=1, AdcSclk=0 and DataOut=0 in the same cycle; no DataValid; normal frame on the first wrap after release.
- SAMPLE_PERIOD=50 -> conversions back to back, one DataValid per frame, no lost or duplicate pulses over 10 frames.
- ADC_RANGE_CHECK_EN defined, MISO stuck high -> RangeError pulses each frame, DataValid never pulses, DataOut holds its previous value. Without the macro, the same stimulus gives DataOut=+511 with DataValid.

Source files
------------

// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: drives a 10-bit SPI ADC at a fixed rate and emits signed samples with a valid strobe.
// Define ADC_RANGE_CHECK_EN to reject frames whose leading/null bits are not zero (RangeError pulse).
module adc_spi_sampler #(
  parameter int unsigned CLK_DIV       = 25,
  parameter int unsigned SAMPLE_PERIOD = 250000,
  parameter int unsigned CHANNEL       = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Enable,
  input  logic              AdcMiso,
  output logic              AdcSclk,
  output logic              AdcCsN,
  output logic              AdcMosi,
  output logic signed [9:0] DataOut,
  output logic              DataValid,
  output logic              RangeError
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned TMR_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
`ifdef ADC_RANGE_CHECK_EN
  localparam int unsigned RX_W = 16;
`else
  // Only the conversion result is ever consumed, so keep just the last 10 bits shifted in.
  localparam int unsigned RX_W = 10;
`endif
  localparam logic [15:0] CMD = 16'hD000 | (16'(CHANNEL % 2) << 13);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [TMR_W-1:0] r_timer;
  logic [4:0]       r_bits;
  logic [15:0]      r_tx;
  logic [RX_W-1:0]  r_rx;
  logic             r_pend;

  logic w_wrap;
  logic w_div_end;
  logic w_start;

  assign w_wrap    = (r_timer == TMR_W'(SAMPLE_PERIOD - 1));
  assign w_div_end = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_start   = (r_state == S_IDLE) && r_pend && Enable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_wrap) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_bits     <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_pend     <= 1'b0;
      AdcSclk    <= 1'b0;
      AdcCsN     <= 1'b1;
      AdcMosi    <= 1'b0;
      DataOut    <= '0;
      DataValid  <= 1'b0;
      RangeError <= 1'b0;
    end else begin
      DataValid  <= 1'b0;
      RangeError <= 1'b0;
      // A fresh wrap wins over consumption; dropping Enable discards any waiting tick.
      r_pend     <= Enable && (w_wrap || (r_pend && !w_start));
      case (r_state)
        S_IDLE: begin
          r_div <= '0;
          if (w_start) begin
            r_state <= S_CS_SETUP;
            AdcCsN  <= 1'b0;
            AdcMosi <= CMD[15];
            r_tx    <= {CMD[14:0], 1'b0};
            r_bits  <= '0;
          end
        end
        S_CS_SETUP: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_state <= S_SHIFT;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_SHIFT: begin
          if (w_div_end) begin
            r_div   <= '0;
            AdcSclk <= ~AdcSclk;
            if (!AdcSclk) begin
              r_rx <= {r_rx[RX_W-2:0], AdcMiso};
            end else begin
              AdcMosi <= r_tx[15];
              r_tx    <= {r_tx[14:0], 1'b0};
              r_bits  <= r_bits + 5'd1;
              if (r_bits == 5'd15) begin
                r_state <= S_CS_HOLD;
              end
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_CS_HOLD: begin
          if (w_div_end) begin
            r_div   <= '0;
            AdcCsN  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
`ifdef ADC_RANGE_CHECK_EN
          if (r_rx[15:10] != 6'd0) begin
            RangeError <= 1'b1;
          end else begin
            DataOut   <= {~r_rx[9], r_rx[8:0]};
            DataValid <= 1'b1;
          end
`else
          DataOut   <= {~r_rx[9], r_rx[8:0]};
          DataValid <= 1'b1;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: cycle-level timing model plus directed literal checks,
// and a second back-to-back instance checked with a sample scoreboard.
module tb_adc_spi_sampler;

  localparam int CD   = 2;
  localparam int SP   = 100;
  localparam int SP_B = 50;
  localparam int CONV = 34 * CD + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, en = 1'b0, miso_a = 1'b0;
  logic sclk_a, csn_a, mosi_a, dv_a, rerr_a;
  logic signed [9:0] dout_a;

  logic rst_b = 1'b0, en_b = 1'b1, miso_b = 1'b0;
  logic sclk_b, csn_b, mosi_b, dv_b, rerr_b;
  logic signed [9:0] dout_b;

  adc_spi_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .CHANNEL(1)) u_dut (
    .clk(clk), .reset(rst), .Enable(en), .AdcMiso(miso_a), .AdcSclk(sclk_a), .AdcCsN(csn_a),
    .AdcMosi(mosi_a), .DataOut(dout_a), .DataValid(dv_a), .RangeError(rerr_a));

  adc_spi_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP_B), .CHANNEL(0)) u_dut_b2b (
    .clk(clk), .reset(rst_b), .Enable(en_b), .AdcMiso(miso_b), .AdcSclk(sclk_b), .AdcCsN(csn_b),
    .AdcMosi(mosi_b), .DataOut(dout_b), .DataValid(dv_b), .RangeError(rerr_b));

  int checks = 0, errors = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  // ADC model for instance A: frames from a directed queue, otherwise random
  logic [15:0] frame_q[$];
  logic [15:0] adc_frame_a = '0;
  int idx_a = 0;
  always @(negedge csn_a) begin
    if (frame_q.size() > 0) adc_frame_a = frame_q.pop_front();
    else begin
      adc_frame_a[9:0]   = 10'($urandom_range(0, 1023));
      adc_frame_a[15:10] = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'd0;
    end
    idx_a  = 15;
    miso_a = adc_frame_a[15];
  end
  always @(negedge sclk_a) if (csn_a === 1'b0) begin
    idx_a--;
    miso_a = (idx_a >= 0) ? adc_frame_a[idx_a[3:0]] : 1'b0;
  end

  logic [15:0] mon_mosi = '0;
  int mon_rises = 0, cs_falls = 0;
  always @(negedge csn_a) begin mon_mosi = '0; mon_rises = 0; cs_falls++; end
  always @(posedge sclk_a) begin mon_mosi = {mon_mosi[14:0], mosi_a}; mon_rises++; end

  int ecnt = 0;
  always @(posedge clk or posedge rst) if (rst) ecnt = 0; else ecnt++;

  // Reference model: a conversion occupies CONV clocks, pins derived from elapsed clocks j
  logic [15:0] cmd_v = 16'hF000;
  int m_t, m_j, m_dout, m_falls;
  bit m_pend, m_busy, m_wrap, m_start, m_bad;
  bit e_csn = 1, e_sclk = 0, e_mosi = 0, e_dv = 0, e_rerr = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t = 0; m_j = 0; m_pend = 0; m_busy = 0; m_dout = 0;
      e_csn = 1; e_sclk = 0; e_mosi = 0; e_dv = 0; e_rerr = 0;
    end else begin
      m_wrap = (m_t == SP - 1);
      m_t    = (m_t + 1) % SP;
      e_dv = 0; e_rerr = 0;
      m_start = !m_busy && m_pend && en;
      if (m_busy) begin
        m_j++;
        if (m_j == CONV) begin
          m_busy = 0;
`ifdef ADC_RANGE_CHECK_EN
          m_bad = (adc_frame_a[15:10] != 6'd0);
`else
          m_bad = 0;
`endif
          if (m_bad) e_rerr = 1;
          else begin e_dv = 1; m_dout = int'(adc_frame_a[9:0]) - 512; end
        end
      end else if (m_start) begin
        m_busy = 1; m_j = 0;
      end
      m_pend  = en && (m_wrap || (m_pend && !m_start));
      e_csn   = !(m_busy && m_j < 34 * CD);
      e_sclk  = m_busy && m_j >= 2 * CD && m_j < 34 * CD && ((m_j - 2 * CD) % (2 * CD)) < CD;
      m_falls = (!m_busy || m_j < 3 * CD) ? 0 : (m_j - 3 * CD) / (2 * CD) + 1;
      if (m_falls > 16) m_falls = 16;
      e_mosi  = m_busy && m_falls < 16 && cmd_v[15 - m_falls];
    end
  end

  always @(negedge clk) if (!rst) begin
    chk("csn", int'(csn_a), int'(e_csn));
    chk("sclk", int'(sclk_a), int'(e_sclk));
    chk("mosi", int'(mosi_a), int'(e_mosi));
    chk("dvalid", int'(dv_a), int'(e_dv));
    chk("rangeerr", int'(rerr_a), int'(e_rerr));
    chk("dout", int'(dout_a), m_dout);
  end

  // Instance B: back-to-back conversions, scoreboard of pushed codes
  int qb[$];
  logic [15:0] frame_b = '0;
  int idx_b = 0, b_cs = 0, b_n = 0, b_cyc = 0, b_last = 0;
  always @(negedge csn_b) begin
    frame_b = {6'd0, 10'($urandom_range(0, 1023))};
    qb.push_back(int'(frame_b[9:0]) - 512);
    idx_b = 15; miso_b = frame_b[15]; b_cs++;
  end
  always @(negedge sclk_b) if (csn_b === 1'b0) begin
    idx_b--;
    miso_b = (idx_b >= 0) ? frame_b[idx_b[3:0]] : 1'b0;
  end
  always @(negedge clk) begin
    b_cyc++;
    if (!rst_b && dv_b) begin
      if (qb.size() == 0) chk("b2b_extra_pulse", 1, 0);
      else chk("b2b_dout", int'(dout_b), qb.pop_front());
      if (b_n > 0) chk("b2b_interval", b_cyc - b_last, CONV + 1);
      b_last = b_cyc;
      b_n++;
    end
  end

  task automatic wait_cs(input logic lvl, input int maxc, input string nm);
    bit ok = 0;
    for (int i = 0; i < maxc; i++) begin
      if (csn_a === lvl) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk(nm, int'(ok), 1);
  endtask

  task automatic wait_dv(input int maxc, output int cyc, output bit ok);
    ok = 0; cyc = 0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #1; cyc++;
      if (dv_a) begin ok = 1; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int cyc, t_prev, f0, e0, exp_start;
    bit ok;
    int exp_vals[3] = '{511, -512, -1};
    #1 rst = 1; rst_b = 1;
    #1;
    chk("rst_csn", int'(csn_a), 1);
    chk("rst_sclk", int'(sclk_a), 0);
    chk("rst_mosi", int'(mosi_a), 0);
    chk("rst_dout", int'(dout_a), 0);
    chk("rst_dvalid", int'(dv_a), 0);
    chk("rst_rangeerr", int'(rerr_a), 0);
    repeat (3) @(posedge clk);
    #3 rst = 0; rst_b = 0;
    @(negedge clk) en = 1;

    frame_q.push_back(16'h0200);
    wait_cs(1'b0, SP + 10, "first_start_seen");
    chk("first_start_edge", ecnt, SP + 1);
    wait_dv(CONV + 5, cyc, ok);
    chk("first_latency", cyc, 69);
    chk("first_dout", int'(dout_a), 0);
    chk("mosi_bits", int'(mon_mosi), 'hF000);
    chk("sclk_rises", mon_rises, 16);
    t_prev = ecnt;

    frame_q.push_back(16'h03FF); frame_q.push_back(16'h0000); frame_q.push_back(16'h01FF);
    for (int k = 0; k < 3; k++) begin
      wait_cs(1'b0, SP + 10, "seq_start_seen");
      wait_dv(CONV + 5, cyc, ok);
      chk("seq_pulse", int'(ok), 1);
      chk("seq_dout", int'(dout_a), exp_vals[k]);
      chk("seq_spacing", ecnt - t_prev, 100);
      t_prev = ecnt;
    end

    wait_cs(1'b0, SP + 10, "drop_start_seen");
    repeat (CD + 10) @(posedge clk);
    @(negedge clk) en = 0;
    wait_dv(CONV, cyc, ok);
    chk("drop_publishes", int'(ok), 1);
    f0 = cs_falls;
    repeat (250) @(negedge clk);
    chk("no_cs_while_disabled", cs_falls - f0, 0);
    en = 1;
    e0 = ecnt;
    exp_start = ((e0 + SP) / SP) * SP + 1;
    wait_cs(1'b0, SP + 10, "restart_seen");
    chk("restart_edge", ecnt, exp_start);

    repeat (CD + 6) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("midrst_csn", int'(csn_a), 1);
    chk("midrst_sclk", int'(sclk_a), 0);
    chk("midrst_dout", int'(dout_a), 0);
    chk("midrst_dvalid", int'(dv_a), 0);
    repeat (2) @(posedge clk);
    #3 rst = 0;
    wait_cs(1'b0, SP + 10, "post_reset_seen");
    chk("post_reset_start", ecnt, SP + 1);
    wait_dv(CONV + 5, cyc, ok);
    chk("post_reset_publish", int'(ok), 1);

    for (int s = 0; s < 25; s++) begin
      @(negedge clk) en = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(20, 250)) @(negedge clk);
    end

    @(negedge clk) en = 1;
    wait_cs(1'b1, CONV + 5, "idle_before_known");
    frame_q.push_back(16'h02A5);
    wait_cs(1'b0, SP + 10, "known_start_seen");
    wait_dv(CONV + 5, cyc, ok);
    chk("known_dout", int'(dout_a), 165);
    frame_q.push_back(16'hFFFF); frame_q.push_back(16'hFFFF);
    for (int k = 0; k < 2; k++) begin
      wait_cs(1'b0, SP + 10, "stuck_start_seen");
      wait_cs(1'b1, CONV + 5, "stuck_end_seen");
      @(posedge clk); #1;
`ifdef ADC_RANGE_CHECK_EN
      chk("stuck_rangeerr", int'(rerr_a), 1);
      chk("stuck_dvalid", int'(dv_a), 0);
      chk("stuck_dout_held", int'(dout_a), 165);
`else
      chk("stuck_rangeerr", int'(rerr_a), 0);
      chk("stuck_dvalid", int'(dv_a), 1);
      chk("stuck_dout", int'(dout_a), 511);
`endif
    end

    chk("b2b_frames_ge10", int'(b_n >= 10), 1);
    chk("b2b_balance", int'((b_cs - b_n) == 0 || (b_cs - b_n) == 1), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
